edac_scrub_ctrl: RTL and testbench



---
 rtl/edac_scrub_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_edac_scrub_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edac_scrub_ctrl.sv
// Background scrub engine for the EDAC-protected RAM: walks an address window,
// re-reads each word through the decoder, writes back corrected codewords and counts events.
module edac_scrub_ctrl #(
  parameter int DAT_WIDTH    = 16,
  parameter int PAR_WIDTH    = 5,
  parameter int RAM_LOGDEPTH = 8,
  parameter int SCRUB_AMIN   = 0,
  parameter int SCRUB_AMAX   = 255,
  parameter int RD_LAT       = 2,
  parameter int DIV_WDTH     = 20,
  parameter int TMOUT_SET    = 10,
  parameter int CNT_WIDTH    = 8,
  parameter int WRBK_ON      = 1,
  parameter int TMR          = 0
) (
  input  logic                              rClk,
  input  logic                              rst,
  input  logic                              start_scrub,
  input  logic                              stop_scrub,
  input  logic                              rst_timer,
  input  logic                              user_req,
  input  logic                              user_wEn,
  input  logic [RAM_LOGDEPTH-1:0]           user_wA,
  input  logic [DAT_WIDTH+PAR_WIDTH-1:0]    dec_code,
  input  logic                              dec_correctable,
  input  logic                              dec_error,
  input  logic [2:0]                        tmr_inj,
  output logic                              ram_rEn,
  output logic [RAM_LOGDEPTH-1:0]           ram_rA,
  output logic                              ram_wEn,
  output logic [RAM_LOGDEPTH-1:0]           ram_wA,
  output logic [DAT_WIDTH+PAR_WIDTH-1:0]    ram_wD,
  output logic                              now_scrubbing,
  output logic                              tmoutflg,
  output logic                              scrub_done,
  output logic                              scrub_corr,
  output logic [CNT_WIDTH-1:0]              corr_cnt,
  output logic [CNT_WIDTH-1:0]              uncorr_cnt,
  output logic                              lane_mismatch
);

  localparam int CW    = DAT_WIDTH + PAR_WIDTH;
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [RAM_LOGDEPTH-1:0] AMIN_A   = RAM_LOGDEPTH'(SCRUB_AMIN);
  localparam logic [RAM_LOGDEPTH-1:0] AMAX_A   = RAM_LOGDEPTH'(SCRUB_AMAX);
  localparam logic [DIV_WDTH-1:0]     TMO_LAST = DIV_WDTH'(TMOUT_SET - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_WRBK = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // All control state lives in one packed record so it can be voted as a flat vector.
  typedef struct packed {
    state_t                  state;
    logic [RAM_LOGDEPTH-1:0] addr;
    logic [LAT_W-1:0]        lat;
    logic [DIV_WDTH-1:0]     timer;
    logic [CNT_WIDTH-1:0]    corr_cnt;
    logic [CNT_WIDTH-1:0]    uncorr_cnt;
    logic                    scrub_corr;
    logic                    coll;
    logic                    tmo;
    logic [CW-1:0]           code;
  } ctx_t;

  localparam int W = $bits(ctx_t);

  ctx_t           cur, nxt, rst_c, inj_c;
  logic [W-1:0]   voted_bits, nxt_bits, rst_bits, inj_bits;
  logic           hit, expire, advance;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    rst_c       = '0;
    rst_c.state = S_IDLE;
    rst_c.addr  = AMIN_A;
    inj_c         = '0;
    inj_c.addr[0] = 1'b1;
  end

  assign rst_bits = rst_c;
  assign inj_bits = inj_c;
  assign nxt_bits = nxt;
  assign cur      = ctx_t'(voted_bits);
  assign hit      = user_wEn && (user_wA == cur.addr);
  assign expire   = (cur.timer == TMO_LAST) && !rst_timer;

  if (TMR != 0) begin : g_tmr
    logic [W-1:0] lane_q [3];
    logic         mism_q;

    always_ff @(posedge rClk) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (rst) lane_q[i] <= rst_bits;
        else     lane_q[i] <= nxt_bits ^ (tmr_inj[i] ? inj_bits : '0);
      end
    end

    always_ff @(posedge rClk) begin
      if (rst)
        mism_q <= 1'b0;
      else if (|((lane_q[0] ^ lane_q[1]) | (lane_q[1] ^ lane_q[2])))
        mism_q <= 1'b1;
    end

    assign voted_bits    = (lane_q[0] & lane_q[1]) | (lane_q[1] & lane_q[2]) | (lane_q[0] & lane_q[2]);
    assign lane_mismatch = mism_q;
  end else begin : g_single
    logic [W-1:0] lane_q;
    logic         unused_inj;

    always_ff @(posedge rClk) begin
      if (rst) lane_q <= rst_bits;
      else     lane_q <= nxt_bits;
    end

    assign voted_bits    = lane_q;
    assign lane_mismatch = 1'b0;
    assign unused_inj    = ^tmr_inj;
  end

  always_comb begin
    nxt       = cur;
    nxt.tmo   = 1'b0;
    nxt.timer = '0;
    advance   = 1'b0;
    ram_rEn   = 1'b0;
    ram_rA    = '0;
    ram_wEn   = 1'b0;
    ram_wA    = '0;
    ram_wD    = '0;

    if (stop_scrub && (cur.state != S_IDLE)) begin
      nxt.state = S_IDLE;
      nxt.addr  = AMIN_A;
    end else begin
      case (cur.state)
        S_IDLE: begin
          if (start_scrub || expire) begin
            nxt.state      = S_READ;
            nxt.scrub_corr = 1'b0;
            nxt.tmo        = expire;
          end else begin
            nxt.timer = cur.timer + DIV_WDTH'(1);
          end
        end
        S_READ: begin
          if (!user_req) begin
            ram_rEn   = 1'b1;
            ram_rA    = cur.addr;
            nxt.lat   = LAT_W'(RD_LAT);
            nxt.coll  = hit;
            nxt.state = S_WAIT;
          end
        end
        S_WAIT: begin
          nxt.coll = cur.coll | hit;
          nxt.lat  = cur.lat - LAT_W'(1);
          if (cur.lat == LAT_W'(1)) begin
            if (dec_error)
              nxt.uncorr_cnt = sat_inc(cur.uncorr_cnt);
            if (dec_correctable) begin
              nxt.corr_cnt   = sat_inc(cur.corr_cnt);
              nxt.scrub_corr = 1'b1;
            end
            if (dec_correctable && (WRBK_ON != 0) && !(cur.coll | hit)) begin
              nxt.state = S_WRBK;
              nxt.code  = dec_code;
            end else begin
              advance = 1'b1;
            end
          end
        end
        S_WRBK: begin
          nxt.coll = cur.coll | hit;
          if (!user_req) begin
            // A user write to this address during stalls still cancels the write-back.
            if (!(cur.coll | hit)) begin
              ram_wEn = 1'b1;
              ram_wA  = cur.addr;
              ram_wD  = cur.code;
            end
            advance = 1'b1;
          end
        end
        S_DONE: begin
          nxt.state = S_IDLE;
          nxt.addr  = AMIN_A;
        end
        default: nxt.state = S_IDLE;
      endcase

      if (advance) begin
        if (cur.addr == AMAX_A) begin
          nxt.state = S_DONE;
        end else begin
          nxt.addr  = cur.addr + RAM_LOGDEPTH'(1);
          nxt.state = S_READ;
        end
      end
    end

    if (rst_timer) nxt.timer = '0;
  end

  assign now_scrubbing = (cur.state != S_IDLE);
  assign tmoutflg      = cur.tmo;
  assign scrub_done    = (cur.state == S_DONE) && !stop_scrub;
  assign scrub_corr    = cur.scrub_corr;
  assign corr_cnt      = cur.corr_cnt;
  assign uncorr_cnt    = cur.uncorr_cnt;

endmodule

// File: tb/tb_edac_scrub_ctrl.sv
// Directed bench for edac_scrub_ctrl: a plain and a triplicated instance run in lockstep
// over a 4-word window against hand-computed event cycles.
module tb_edac_scrub_ctrl;
  localparam int AW   = 8;
  localparam int CW   = 21;
  localparam int CNTW = 4;

  logic          rClk = 1'b0;
  logic          rst = 1'b1, start_scrub = 1'b0, stop_scrub = 1'b0, rst_timer = 1'b1;
  logic          user_req = 1'b0, user_wEn = 1'b0;
  logic [AW-1:0] user_wA = '0;
  logic [2:0]    tmr_inj = '0;
  logic [CW-1:0] dec_code;
  logic          dec_correctable, dec_error;

  logic          rd_en [2], wr_en [2], nscrub [2], tmo [2], done [2], scorr [2], lmis [2];
  logic [AW-1:0] rd_a [2], wr_a [2];
  logic [CW-1:0] wr_d [2];
  logic [CNTW-1:0] ccnt [2], ucnt [2];

  always #5 rClk = ~rClk;

  edac_scrub_ctrl #(
    .DAT_WIDTH(16), .PAR_WIDTH(5), .RAM_LOGDEPTH(AW), .SCRUB_AMIN(0), .SCRUB_AMAX(3),
    .RD_LAT(2), .DIV_WDTH(8), .TMOUT_SET(10), .CNT_WIDTH(CNTW), .WRBK_ON(1), .TMR(0)
  ) dut (
    .rClk(rClk), .rst(rst), .start_scrub(start_scrub), .stop_scrub(stop_scrub),
    .rst_timer(rst_timer), .user_req(user_req), .user_wEn(user_wEn), .user_wA(user_wA),
    .dec_code(dec_code), .dec_correctable(dec_correctable), .dec_error(dec_error),
    .tmr_inj(tmr_inj), .ram_rEn(rd_en[0]), .ram_rA(rd_a[0]), .ram_wEn(wr_en[0]),
    .ram_wA(wr_a[0]), .ram_wD(wr_d[0]), .now_scrubbing(nscrub[0]), .tmoutflg(tmo[0]),
    .scrub_done(done[0]), .scrub_corr(scorr[0]), .corr_cnt(ccnt[0]), .uncorr_cnt(ucnt[0]),
    .lane_mismatch(lmis[0])
  );

  edac_scrub_ctrl #(
    .DAT_WIDTH(16), .PAR_WIDTH(5), .RAM_LOGDEPTH(AW), .SCRUB_AMIN(0), .SCRUB_AMAX(3),
    .RD_LAT(2), .DIV_WDTH(8), .TMOUT_SET(10), .CNT_WIDTH(CNTW), .WRBK_ON(1), .TMR(1)
  ) dut_tmr (
    .rClk(rClk), .rst(rst), .start_scrub(start_scrub), .stop_scrub(stop_scrub),
    .rst_timer(rst_timer), .user_req(user_req), .user_wEn(user_wEn), .user_wA(user_wA),
    .dec_code(dec_code), .dec_correctable(dec_correctable), .dec_error(dec_error),
    .tmr_inj(tmr_inj), .ram_rEn(rd_en[1]), .ram_rA(rd_a[1]), .ram_wEn(wr_en[1]),
    .ram_wA(wr_a[1]), .ram_wD(wr_d[1]), .now_scrubbing(nscrub[1]), .tmoutflg(tmo[1]),
    .scrub_done(done[1]), .scrub_corr(scorr[1]), .corr_cnt(ccnt[1]), .uncorr_cnt(ucnt[1]),
    .lane_mismatch(lmis[1])
  );

  // Decoder stand-in: flags appear two cycles after the read strobe, per-address masks.
  logic [1:0]    pv;
  logic [AW-1:0] pa0, pa1;
  logic [3:0]    corr_mask = '0, err_mask = '0;

  always @(posedge rClk) begin
    if (rst) begin
      pv <= '0; pa0 <= '0; pa1 <= '0;
    end else begin
      pv <= {pv[0], rd_en[0]}; pa0 <= rd_a[0]; pa1 <= pa0;
    end
  end

  assign dec_correctable = pv[1] && corr_mask[pa1[1:0]];
  assign dec_error       = pv[1] && err_mask[pa1[1:0]];
  assign dec_code        = pv[1] ? 21'h1ABCD : '0;

  int cyc = 0, t0 = 0;
  always @(posedge rClk) cyc <= cyc + 1;

  int n_rd [2], rd_c [2][16], rd_ad [2][16];
  int n_wr [2], wr_c [2][16], wr_ad [2][16];
  logic [CW-1:0] wr_dd [2][16];
  int n_done [2], done_c [2];
  int lm_c = -1, bus_viol = 0, end_rel = 0;
  int checks = 0, failures = 0;

  always @(negedge rClk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k]) begin
        if (n_rd[k] < 16) begin rd_c[k][n_rd[k]] = cyc - t0; rd_ad[k][n_rd[k]] = int'(rd_a[k]); end
        n_rd[k]++;
      end else if (rd_a[k] != '0) bus_viol++;
      if (wr_en[k]) begin
        if (n_wr[k] < 16) begin
          wr_c[k][n_wr[k]] = cyc - t0; wr_ad[k][n_wr[k]] = int'(wr_a[k]); wr_dd[k][n_wr[k]] = wr_d[k];
        end
        n_wr[k]++;
      end else if (wr_a[k] != '0 || wr_d[k] != '0) bus_viol++;
      if (done[k]) begin done_c[k] = cyc - t0; n_done[k]++; end
    end
    if (lmis[1] && lm_c < 0) lm_c = cyc - t0;
  end

  int ureq_lo = -1, ureq_hi = -2, uwe_at = -1, stop_at = -1, inj_at = -1;
  logic [AW-1:0] uwa = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rClk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic run_pass(input int budget);
    int  rel;
    bit  timed_out;
    for (int k = 0; k < 2; k++) begin n_rd[k] = 0; n_wr[k] = 0; n_done[k] = 0; done_c[k] = -1; end
    lm_c = -1; t0 = cyc; timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      rel         = cyc - t0;
      start_scrub = (rel == 0) || (rel == stop_at);
      stop_scrub  = (rel == stop_at);
      user_req    = (rel >= ureq_lo) && (rel <= ureq_hi);
      user_wEn    = (rel == uwe_at);
      user_wA     = uwa;
      tmr_inj     = (rel == inj_at) ? 3'b010 : 3'b000;
      step();
      if ((cyc - t0 > 1) && !nscrub[0]) begin timed_out = 1'b0; break; end
    end
    end_rel = cyc - t0;
    start_scrub = 1'b0; stop_scrub = 1'b0; user_req = 1'b0; user_wEn = 1'b0; tmr_inj = '0;
    chk("pass_ends_in_budget", 32'(timed_out), 0);
    chk("tmr_idle_at_end", 32'(nscrub[1]), 0);
    ureq_lo = -1; ureq_hi = -2; uwe_at = -1; stop_at = -1; inj_at = -1;
  endtask

  task automatic chk_reads(input int c0, input int c1, input int c2, input int c3);
    int ec [4];
    ec = '{c0, c1, c2, c3};
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_count[%0d]", k), n_rd[k], 4);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("rd_cycle[%0d][%0d]", k, j), rd_c[k][j], ec[j]);
        chk($sformatf("rd_addr[%0d][%0d]", k, j), rd_ad[k][j], j);
      end
    end
  endtask

  task automatic chk_done(input int d, input int e);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done_count[%0d]", k), n_done[k], 1);
      chk($sformatf("done_cycle[%0d]", k), done_c[k], d);
    end
    chk("idle_cycle", end_rel, e);
  endtask

  task automatic chk_cnt(input string tag, input int c, input int u, input int sc);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_corr_cnt[%0d]", tag, k), 32'(ccnt[k]), c);
      chk($sformatf("%s_uncorr_cnt[%0d]", tag, k), 32'(ucnt[k]), u);
      chk($sformatf("%s_scrub_corr[%0d]", tag, k), 32'(scorr[k]), sc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_strobes[%0d]", k), {rd_en[k], wr_en[k], nscrub[k], tmo[k], done[k], scorr[k], lmis[k]}, 0);
      chk($sformatf("rst_buses[%0d]", k), {3'b0, rd_a[k], wr_a[k]} | 32'(wr_d[k]), 0);
    end
    chk_cnt("rst", 0, 0, 0);

    // Clean pass over addresses 0..3
    run_pass(40);
    chk_reads(1, 4, 7, 10);
    chk_done(13, 14);
    chk("clean_no_wr", n_wr[0] + n_wr[1], 0);
    chk_cnt("clean", 0, 0, 0);

    // Correctable at 2 with write-back, uncorrectable at 0, unrelated user write
    do_reset();
    corr_mask = 4'b0100; err_mask = 4'b0001; uwe_at = 8; uwa = 8'd3;
    run_pass(40);
    chk_reads(1, 4, 7, 11);
    chk_done(14, 15);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wb_count[%0d]", k), n_wr[k], 1);
      chk($sformatf("wb_cycle[%0d]", k), wr_c[k][0], 10);
      chk($sformatf("wb_addr[%0d]", k), wr_ad[k][0], 2);
      chk($sformatf("wb_data[%0d]", k), 32'(wr_dd[k][0]), 32'h1ABCD);
    end
    chk_cnt("wb", 1, 1, 1);

    // Colliding user write to address 2 during WAIT cancels the write-back
    do_reset();
    err_mask = '0; uwe_at = 8; uwa = 8'd2;
    run_pass(40);
    chk_reads(1, 4, 7, 10);
    chk_done(13, 14);
    chk("coll_no_wr", n_wr[0] + n_wr[1], 0);
    chk_cnt("coll", 1, 0, 1);

    // User stall of three cycles in READ of address 1; scrub_corr clears on restart
    corr_mask = '0; ureq_lo = 4; ureq_hi = 6;
    run_pass(40);
    chk_reads(1, 7, 10, 13);
    chk_done(16, 17);
    chk_cnt("stall", 1, 0, 0);

    // Stop during WAIT of address 1, with a simultaneous start that must be ignored
    stop_at = 5;
    run_pass(40);
    chk("stop_idle_cycle", end_rel, 6);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stop_no_done[%0d]", k), n_done[k], 0);
      chk($sformatf("stop_reads[%0d]", k), n_rd[k], 2);
      chk($sformatf("stop_last_addr[%0d]", k), rd_ad[k][1], 1);
    end
    run_pass(40);
    chk_reads(1, 4, 7, 10);
    chk_done(13, 14);

    // Interval timer: expiry ten cycles after reset starts a pass
    rst_timer = 1'b0;
    do_reset();
    t0 = cyc;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i >= 9) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("tmoutflg[%0d]@%0d", k, i), 32'(tmo[k]), 32'(i == 10));
          chk($sformatf("tmo_rEn[%0d]@%0d", k, i), 32'(rd_en[k]), 32'(i == 10));
        end
      end
    end
    rst_timer = 1'b1;

    // Lane upset in the triplicated instance
    do_reset();
    inj_at = 5;
    run_pass(40);
    chk_reads(1, 4, 7, 10);
    chk_done(13, 14);
    chk("lane_mismatch_cycle", lm_c, 7);
    chk("lane_mismatch_tmr", 32'(lmis[1]), 1);
    chk("lane_mismatch_plain", 32'(lmis[0]), 0);

    // Counter saturation: 20 correctable words into a 4-bit counter
    do_reset();
    corr_mask = 4'hF;
    for (int p = 0; p < 3; p++) run_pass(60);
    chk_reads(1, 5, 9, 13);
    chk_done(17, 18);
    chk("sat_wr_count", n_wr[0], 4);
    chk_cnt("mid", 12, 0, 1);
    for (int p = 0; p < 2; p++) run_pass(60);
    chk_cnt("sat", 15, 0, 1);

    // Reset in the middle of a pass
    start_scrub = 1'b1; step(); start_scrub = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_busy", 32'(nscrub[0]), 1);
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_busy[%0d]", k), 32'(nscrub[k]), 0);
      chk($sformatf("midrst_rEn[%0d]", k), 32'(rd_en[k]), 0);
    end
    chk_cnt("midrst", 0, 0, 0);
    corr_mask = '0;

    chk("bus_idle_zero", bus_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
